step_ramp_gen: RTL and testbench
================================

# step_ramp_gen

Step-rate generator with a trapezoidal acceleration/deceleration ramp. It sits directly upstream of the coil-sequencing stage and replaces a fixed-period toggle clock as the source of step events. It converts the run, direction and speed-select levels into single-cycle step strobes whose interval ramps between a start period and a target period. Direction changes only while stopped, so the sequencer never reverses at speed.

## Interface
Parameters:
- W, 20, width of period and interval counter
- START_PERIOD, 100000, interval (clk cycles) of first and last step; stop threshold
- SLOW_PERIOD, 67500, cruise interval when fast=0
- FAST_PERIOD, 2000, cruise interval when fast=1
- RAMP_DELTA, 2000, period change per step while ramping
- Legal range: 1 <= FAST_PERIOD <= SLOW_PERIOD <= START_PERIOD < 2^W; RAMP_DELTA >= 1

Ports:
- clk  in  1  system clock (27 MHz on Tang Nano 9K)
- rst  in  1  reset; synchronous, active-high
- run  in  1  level; 1 = motion requested (already synchronised/debounced)
- dir_in  in  1  requested direction (0 = clockwise, 1 = anti-clockwise)
- fast  in  1  speed select (1 = FAST_PERIOD target, 0 = SLOW_PERIOD target)
- step  out  1  one-cycle strobe per motor step
- dir  out  1  latched direction, valid with every step
- moving  out  1  state != IDLE
- at_speed  out  1  state == CRUISE

## Operation
- Internal state: FSM {IDLE, ACCEL, CRUISE, DECEL}, period register (W bits), interval counter cnt (W bits).
- IDLE:
  - period = START_PERIOD, cnt = 0.
  - When run = 1 at an edge: dir <= dir_in, state <= ACCEL.
- Moving states (ACCEL, CRUISE, DECEL):
  - cnt increments every cycle.
  - At the edge where cnt == period-1 (the "step edge"): step <= 1, cnt <= 0, and the decision below is made. step is 0 at every other edge.
- Inputs are sampled only at step edges (and in IDLE). A started interval always completes with its step.
- Decision at a step edge: let stop = !run || (dir_in != dir).
  - stop and period+RAMP_DELTA >= START_PERIOD: state <= IDLE. The strobe just issued is the last step.
  - stop otherwise: period <= period+RAMP_DELTA, state <= DECEL.
  - not stop, with target T = fast ? FAST_PERIOD : SLOW_PERIOD:
    - period > T: period <= max(period-RAMP_DELTA, T); state <= CRUISE if the result equals T, else ACCEL.
    - period < T: period <= min(period+RAMP_DELTA, T); state <= CRUISE if the result equals T, else DECEL.
    - period == T: state <= CRUISE.
- Direction reversal: decelerate to IDLE, spend one IDLE cycle, then restart in ACCEL with the new dir.
- Arithmetic: sums and differences are computed in W+1 bits and clamped. The period never wraps and never leaves [FAST_PERIOD, START_PERIOD].
- dir changes only on the IDLE->ACCEL edge.

## Timing
- Reset values: step=0, dir=0, moving=0, at_speed=0, state=IDLE, period=START_PERIOD, cnt=0.
- Reset mid-operation: at the next edge all of the above are restored. No further step is issued.
- All outputs are registered. No combinational path from inputs to outputs.
- Start latency: run sampled 1 at edge k (in IDLE) -> first step high in the cycle after edge k+START_PERIOD.
- Step spacing: consecutive strobes are exactly the old period value apart. The new period applies to the interval that starts at the step edge.
- Minimum stop: a run pulse of any length >= 1 cycle produces at least one step.
- moving falls at the same edge as the final step strobe. at_speed changes only at step edges.
- run, fast and dir_in changes between step edges have no effect until the next step edge.

## Test plan
Use START=10, SLOW=8, FAST=4, DELTA=2, W=8.
- Reset, then hold run=0 for 50 cycles -> step never asserts; moving=0, at_speed=0, dir=0.
- run=1, fast=1, dir_in=0 from edge k -> steps at k+10, +8, +6, +4, +4 (intervals 10, 8, 6, 4, 4); at_speed rises with the 3rd step; dir=0.
- From fast cruise, drop run mid-interval -> exactly 3 further steps, intervals 4, 6, 8; moving falls with the last step; at_speed falls with the first of these steps.
- From fast cruise, flip dir_in to 1 with run=1 -> decel steps (intervals 4, 6, 8), one IDLE cycle, then dir=1 and new steps at intervals 10, 8, 6, 4. No step is ever issued with the wrong dir.
- From fast cruise, set fast=0 -> intervals 4, 6, 8, 8, ...; at_speed low for one interval, then high again.
- run high for 1 cycle from IDLE -> exactly one step, 10 cycles later, then IDLE. Separately, assert rst during ACCEL -> the next cycle matches the reset values, with no step.

Source files
------------

// File: rtl/step_ramp_gen_if.sv
// Control levels in, step strobe and status out, between the ramp generator and its user.
interface step_ramp_gen_if;
    logic run;
    logic dir_in;
    logic fast;
    logic step;
    logic dir;
    logic moving;
    logic at_speed;

    modport master (
        output run, dir_in, fast,
        input  step, dir, moving, at_speed
    );

    modport slave (
        input  run, dir_in, fast,
        output step, dir, moving, at_speed
    );
endinterface

// File: rtl/step_ramp_gen.sv
// Step-rate generator: one-cycle step strobes whose interval ramps between
// START_PERIOD and the selected cruise period by RAMP_DELTA per step.
module step_ramp_gen #(
    parameter int unsigned W            = 20,
    parameter int unsigned START_PERIOD = 100000,
    parameter int unsigned SLOW_PERIOD  = 67500,
    parameter int unsigned FAST_PERIOD  = 2000,
    parameter int unsigned RAMP_DELTA   = 2000
) (
    input logic           clk,
    input logic           rst,
    step_ramp_gen_if.slave bus
);
    localparam int unsigned WX = W + 1;

    localparam logic [W-1:0]  START_P = W'(START_PERIOD);
    localparam logic [WX-1:0] START_X = WX'(START_PERIOD);
    localparam logic [WX-1:0] SLOW_X  = WX'(SLOW_PERIOD);
    localparam logic [WX-1:0] FAST_X  = WX'(FAST_PERIOD);
    localparam logic [WX-1:0] DELTA_X = WX'(RAMP_DELTA);

    typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, DECEL} state_t;

    state_t         state, state_n;
    logic [W-1:0]   period, period_n;
    logic [W-1:0]   cnt, cnt_n;
    logic           dir_n, step_n;
    logic           stop;
    logic [WX-1:0]  period_x, up_x, target_x;

    // Next-state: count out the current interval, decide the next period at its step edge.
    always_comb begin
        state_n  = state;
        period_n = period;
        cnt_n    = cnt;
        dir_n    = bus.dir;
        step_n   = 1'b0;
        period_x = {1'b0, period};
        up_x     = period_x + DELTA_X;
        target_x = bus.fast ? FAST_X : SLOW_X;
        stop     = !bus.run || (bus.dir_in != bus.dir);

        case (state)
            IDLE: begin
                period_n = START_P;
                cnt_n    = '0;
                if (bus.run) begin
                    dir_n   = bus.dir_in;
                    state_n = ACCEL;
                end
            end
            default: begin
                if (cnt == period - W'(1)) begin
                    step_n = 1'b1;
                    cnt_n  = '0;
                    if (stop) begin
                        if (up_x >= START_X) begin
                            period_n = START_P;
                            state_n  = IDLE;
                        end else begin
                            period_n = W'(up_x);
                            state_n  = DECEL;
                        end
                    end else if (period_x > target_x) begin
                        // Speeding up: shorten, clamped so we never undershoot the target.
                        if (period_x > target_x + DELTA_X) begin
                            period_n = W'(period_x - DELTA_X);
                            state_n  = ACCEL;
                        end else begin
                            period_n = W'(target_x);
                            state_n  = CRUISE;
                        end
                    end else if (period_x < target_x) begin
                        if (up_x < target_x) begin
                            period_n = W'(up_x);
                            state_n  = DECEL;
                        end else begin
                            period_n = W'(target_x);
                            state_n  = CRUISE;
                        end
                    end else begin
                        state_n = CRUISE;
                    end
                end else begin
                    cnt_n = cnt + W'(1);
                end
            end
        endcase
    end

    // State and registered outputs; status reflects the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            period       <= START_P;
            cnt          <= '0;
            bus.step     <= 1'b0;
            bus.dir      <= 1'b0;
            bus.moving   <= 1'b0;
            bus.at_speed <= 1'b0;
        end else begin
            state        <= state_n;
            period       <= period_n;
            cnt          <= cnt_n;
            bus.step     <= step_n;
            bus.dir      <= dir_n;
            bus.moving   <= (state_n != IDLE);
            bus.at_speed <= (state_n == CRUISE);
        end
    end
endmodule

// File: tb/tb_step_ramp_gen.sv
// Bench for step_ramp_gen: scenario table, hand-written ramp sequences and a
// randomized run against an event-time reference model.
module tb_step_ramp_gen;
    localparam int START = 10;
    localparam int SLOW  = 8;
    localparam int FAST  = 4;
    localparam int DELTA = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    step_ramp_gen_if sif ();

    step_ramp_gen #(
        .W(8), .START_PERIOD(START), .SLOW_PERIOD(SLOW),
        .FAST_PERIOD(FAST), .RAMP_DELTA(DELTA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif.slave)
    );

    int errors = 0;
    int checks = 0;
    int t = 0;

    // Reference model: motion described by absolute time of the next step.
    bit m_moving = 0, m_cruise = 0, m_dir = 0, m_step = 0;
    int m_period = START;
    int m_next = 0;

    typedef struct { int t; bit dir; bit at_speed; bit moving; } step_rec_t;
    step_rec_t q[$];

    typedef struct {
        bit rst, run, dir_in, fast;
        int cycles;
        int exp_steps;
        bit exp_moving, exp_at_speed, exp_dir;
    } seg_t;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, t);
        end
    endtask

    task automatic model_edge();
        int tgt;
        bit stop;
        m_step = 0;
        if (rst) begin
            m_moving = 0; m_cruise = 0; m_dir = 0; m_period = START;
        end else if (!m_moving) begin
            if (sif.run) begin
                m_moving = 1; m_dir = sif.dir_in; m_period = START;
                m_next = t + START;
            end
        end else if (t == m_next) begin
            m_step = 1;
            stop = !sif.run || (sif.dir_in != m_dir);
            tgt = sif.fast ? FAST : SLOW;
            if (stop) begin
                m_cruise = 0;
                if (m_period + DELTA >= START) m_moving = 0;
                else m_period = m_period + DELTA;
            end else begin
                if (m_period > tgt) m_period = (m_period - DELTA > tgt) ? m_period - DELTA : tgt;
                else if (m_period < tgt) m_period = (m_period + DELTA < tgt) ? m_period + DELTA : tgt;
                m_cruise = (m_period == tgt);
            end
            m_next = t + m_period;
        end
    endtask

    task automatic tick();
        step_rec_t r;
        @(posedge clk);
        t++;
        model_edge();
        #1;
        check("model", int'({sif.step, sif.dir, sif.moving, sif.at_speed}),
              int'({m_step, m_dir, m_moving, m_cruise}));
        if (sif.step) begin
            r.t = t; r.dir = sif.dir; r.at_speed = sif.at_speed; r.moving = sif.moving;
            q.push_back(r);
        end
    endtask

    task automatic do_reset();
        sif.run = 0; sif.dir_in = 0; sif.fast = 0;
        rst = 1; tick(); rst = 0;
        q.delete();
    endtask

    task automatic wait_steps(input int n, input int budget);
        int b = 0;
        while (q.size() < n && b < budget) begin tick(); b++; end
        check("step_wait_timeout", q.size() >= n ? 1 : 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        int b = 0;
        while (sif.moving && b < budget) begin tick(); b++; end
        check("idle_wait_timeout", int'(sif.moving), 0);
    endtask

    task automatic check_offsets(input string name, input int base, input int offs[],
                                 input int n);
        for (int i = 0; i < n && i < q.size(); i++)
            check(name, q[i].t - base, offs[i]);
    endtask

    initial begin
        seg_t tbl[7];
        int offs[];
        int base, k, steps;

        sif.run = 0; sif.dir_in = 0; sif.fast = 0;

        // rst run dir fast cycles steps moving at_speed dir
        tbl[0] = '{1, 0, 0, 0,  1, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 0, 50, 0, 0, 0, 0};
        tbl[2] = '{0, 1, 0, 1, 40, 6, 1, 1, 0};
        tbl[3] = '{0, 0, 0, 1, 30, 3, 0, 0, 0};
        tbl[4] = '{0, 1, 1, 0, 60, 7, 1, 1, 1};
        tbl[5] = '{0, 1, 0, 0, 40, 4, 1, 1, 0};
        tbl[6] = '{1, 1, 0, 0,  1, 0, 0, 0, 0};

        for (int i = 0; i < 7; i++) begin
            rst = tbl[i].rst; sif.run = tbl[i].run;
            sif.dir_in = tbl[i].dir_in; sif.fast = tbl[i].fast;
            steps = 0;
            repeat (tbl[i].cycles) begin tick(); if (sif.step) steps++; end
            check($sformatf("seg%0d_steps", i), steps, tbl[i].exp_steps);
            check($sformatf("seg%0d_moving", i), int'(sif.moving), int'(tbl[i].exp_moving));
            check($sformatf("seg%0d_at_speed", i), int'(sif.at_speed), int'(tbl[i].exp_at_speed));
            check($sformatf("seg%0d_dir", i), int'(sif.dir), int'(tbl[i].exp_dir));
        end
        rst = 0;

        // Fast start: intervals 10,8,6,4,4
        do_reset();
        sif.run = 1; sif.fast = 1; k = t + 1;
        wait_steps(5, 100);
        offs = '{10, 18, 24, 28, 32};
        check_offsets("accel_time", k, offs, 5);
        if (q.size() >= 3) begin
            check("accel_at_speed2", int'(q[1].at_speed), 0);
            check("accel_at_speed3", int'(q[2].at_speed), 1);
        end

        // Drop run mid-interval: 3 more steps at 4,6,8
        base = q[q.size()-1].t; q.delete();
        tick(); tick();
        sif.run = 0;
        wait_idle(100);
        check("stop_count", q.size(), 3);
        offs = '{4, 10, 18};
        check_offsets("stop_time", base, offs, 3);
        if (q.size() == 3) begin
            check("stop_at_speed_first", int'(q[0].at_speed), 0);
            check("stop_moving_mid", int'(q[1].moving), 1);
            check("stop_moving_last", int'(q[2].moving), 0);
        end

        // Reversal at speed: decel, one idle cycle, restart with dir=1
        q.delete();
        sif.run = 1; sif.fast = 1; sif.dir_in = 0;
        wait_steps(5, 100);
        base = q[q.size()-1].t; q.delete();
        tick();
        sif.dir_in = 1;
        wait_steps(7, 200);
        offs = '{4, 10, 18, 29, 37, 43, 47};
        check_offsets("rev_time", base, offs, 7);
        for (int i = 0; i < 7 && i < q.size(); i++)
            check("rev_dir", int'(q[i].dir), i < 3 ? 0 : 1);

        // Fast cruise to slow: intervals 4,6,8,8
        base = q[q.size()-1].t; q.delete();
        tick();
        sif.fast = 0;
        wait_steps(4, 100);
        offs = '{4, 10, 18, 26};
        check_offsets("slow_time", base, offs, 4);
        for (int i = 0; i < 4 && i < q.size(); i++)
            check("slow_at_speed", int'(q[i].at_speed), i == 0 ? 0 : 1);

        // One-cycle run pulse: exactly one step, START later
        sif.run = 0;
        wait_idle(100);
        q.delete();
        sif.run = 1; tick(); k = t; sif.run = 0;
        repeat (30) tick();
        check("pulse_count", q.size(), 1);
        if (q.size() == 1) begin
            check("pulse_time", q[0].t - k, START);
            check("pulse_moving", int'(q[0].moving), 0);
        end

        // Reset during ACCEL
        sif.run = 1; sif.dir_in = 1;
        repeat (5) tick();
        rst = 1; tick();
        check("rst_outputs", int'({sif.step, sif.dir, sif.moving, sif.at_speed}), 0);
        rst = 0; sif.run = 0; q.delete();
        repeat (20) tick();
        check("rst_no_step", q.size(), 0);

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(39, 0) == 0) sif.run = ~sif.run;
            if ($urandom_range(79, 0) == 0) sif.dir_in = ~sif.dir_in;
            if ($urandom_range(59, 0) == 0) sif.fast = ~sif.fast;
            rst = ($urandom_range(1499, 0) == 0);
            tick();
        end
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
